// File: rtl/ram_bank_ctrl_pkg.sv
// rtl/ram_bank_ctrl_pkg.sv - shared constants and FSM state type for the RAM bank controller
// Purpose: bank/data geometry, wait-counter width and the controller state encoding.
// Ports: none (package).
package ram_bank_ctrl_pkg;

  localparam int NUM_BANKS = 16;
  localparam int BANK_W    = 4;
  localparam int DATA_W    = 8;
  // Wide enough to hold READ_LAT-1 for the full legal READ_LAT range of 1..7.
  localparam int CNT_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

endpackage

// File: rtl/ram_bank_ctrl_if.sv
// rtl/ram_bank_ctrl_if.sv - request/response handshake bundle of the RAM bank controller
// Purpose: groups the valid/ready request channel and the valid/ready response channel.
// Ports (signals):
//   req_valid/req_ready/req_we/req_addr/req_wdata  request channel (master -> slave)
//   rsp_valid/rsp_ready/rsp_rdata                  response channel (slave -> master)
// Modports: master = requester, slave = controller.
interface ram_bank_ctrl_if
  import ram_bank_ctrl_pkg::*;
#(
  parameter int WORD_W = 8
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [WORD_W+3:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_bank_ctrl_bank_decode.sv
// rtl/ram_bank_ctrl_bank_decode.sv - 4-to-16 one-hot bank chip-select decoder with enable
// Purpose: turns the latched bank index into a one-hot chip-select while enabled.
// Ports:
//   en      in   1          decoder enable; all outputs 0 when low
//   sel     in   BANK_W     bank index
//   onehot  out  NUM_BANKS  one-hot chip-select
module bank_decode
  import ram_bank_ctrl_pkg::*;
(
  input  logic                 en,
  input  logic [BANK_W-1:0]    sel,
  output logic [NUM_BANKS-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/ram_bank_ctrl.sv
// rtl/ram_bank_ctrl.sv - single-byte read/write sequencer for a 16-bank byte-wide RAM and its read mux
// Purpose: accepts one request at a time, drives bank chip-select/address/data, gates exactly
//   one bank through the mux for one cycle on reads, and returns the captured byte.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          request/response handshake (slave side)
//   bank_cs      out  16      one-hot chip-select, decoded from registered bank + state
//   bank_we      out  1       write strobe (write ACCESS cycle only)
//   bank_addr    out  WORD_W  word address
//   bank_wdata   out  8       write byte
//   mux_sel      out  4       mux select (latched bank while busy, 0 in IDLE)
//   mux_en       out  1       mux enable (CAPTURE only)
//   mux_out      in   8       selected byte from mux
module ram_bank_ctrl
  import ram_bank_ctrl_pkg::*;
#(
  parameter int WORD_W   = 8,
  parameter int READ_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_bank_ctrl_if.slave       bus,
  output logic [NUM_BANKS-1:0] bank_cs,
  output logic                 bank_we,
  output logic [WORD_W-1:0]    bank_addr,
  output logic [DATA_W-1:0]    bank_wdata,
  output logic [BANK_W-1:0]    mux_sel,
  output logic                 mux_en,
  input  logic [DATA_W-1:0]    mux_out
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LAT - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [BANK_W-1:0]   bank_q, bank_d;
  logic [WORD_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                bank_we_q, bank_we_d;
  logic                mux_en_q, mux_en_d;
  logic [BANK_W-1:0]   mux_sel_q, mux_sel_d;
  logic                cs_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    bank_d  = bank_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          state_d = ST_ACCESS;
          cnt_d   = LAT_LOAD;
          we_d    = bus.req_we;
          bank_d  = bus.req_addr[WORD_W +: BANK_W];
          addr_d  = bus.req_addr[WORD_W-1:0];
          wdata_d = bus.req_wdata;
        end
      end
      ST_ACCESS: begin
        if (we_q) begin
          state_d = ST_RESP;
        end else if (cnt_q == '0) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        rdata_d = mux_out;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Registered outputs are computed from the next state so they line up with the state
    // register rather than trailing it by a cycle.
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    bank_we_d   = (state_d == ST_ACCESS) && we_d;
    mux_en_d    = (state_d == ST_CAPTURE);
    mux_sel_d   = (state_d == ST_IDLE) ? '0 : bank_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      bank_q      <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      bank_we_q   <= 1'b0;
      mux_en_q    <= 1'b0;
      mux_sel_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      bank_q      <= bank_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      bank_we_q   <= bank_we_d;
      mux_en_q    <= mux_en_d;
      mux_sel_q   <= mux_sel_d;
    end
  end

  // Chip-select is decoded from registered state so it drops as soon as reset hits.
  assign cs_en = (state_q == ST_ACCESS) || (state_q == ST_CAPTURE);

  bank_decode u_bank_decode (
    .en     (cs_en),
    .sel    (bank_q),
    .onehot (bank_cs)
  );

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bank_we       = bank_we_q;
  assign bank_addr     = addr_q;
  assign bank_wdata    = wdata_q;
  assign mux_sel       = mux_sel_q;
  assign mux_en        = mux_en_q;

endmodule

// File: tb/tb_ram_bank_ctrl.sv
// tb/tb_ram_bank_ctrl.sv - self-checking bench for ram_bank_ctrl (READ_LAT=1 and READ_LAT=3 instances)
module tb_ram_bank_ctrl;
  import ram_bank_ctrl_pkg::*;

  localparam int WORD_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fill = 1'b1;

  logic [1:0]       req_valid, req_we, rsp_ready, req_ready, rsp_valid, bank_we, mux_en;
  logic [1:0][11:0] req_addr;
  logic [1:0][7:0]  req_wdata, rsp_rdata, bank_addr, bank_wdata, mux_out;
  logic [1:0][15:0] bank_cs;
  logic [1:0][3:0]  mux_sel;

  logic [7:0] mem    [2][16][256];
  logic [7:0] shadow [2][16][256];
  int         cs_cnt [2];
  logic [7:0] last_rd [2];
  logic [7:0] exp_q [$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] pat(input int u, input int b, input int w);
    return 8'((b * 16) + (w * 5) + (u * 7));
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ram_bank_ctrl_if #(.WORD_W(WORD_W)) bus ();

    assign bus.req_valid  = req_valid[g];
    assign bus.req_we     = req_we[g];
    assign bus.req_addr   = req_addr[g];
    assign bus.req_wdata  = req_wdata[g];
    assign bus.rsp_ready  = rsp_ready[g];
    assign req_ready[g]   = bus.req_ready;
    assign rsp_valid[g]   = bus.rsp_valid;
    assign rsp_rdata[g]   = bus.rsp_rdata;

    ram_bank_ctrl #(.WORD_W(WORD_W), .READ_LAT(g == 0 ? 1 : 3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .bank_cs    (bank_cs[g]),
      .bank_we    (bank_we[g]),
      .bank_addr  (bank_addr[g]),
      .bank_wdata (bank_wdata[g]),
      .mux_sel    (mux_sel[g]),
      .mux_en     (mux_en[g]),
      .mux_out    (mux_out[g])
    );

    // Bank data is only valid once cs has been held READ_LAT edges; otherwise poison.
    assign mux_out[g] = (mux_en[g] && bank_cs[g][mux_sel[g]] && cs_cnt[g] >= (g == 0 ? 1 : 3))
                        ? mem[g][mux_sel[g]][bank_addr[g]] : 8'hEE;
  end

  always @(posedge clk) begin
    for (int u = 0; u < 2; u++) begin
      if (fill) begin
        for (int b = 0; b < 16; b++)
          for (int w = 0; w < 256; w++)
            mem[u][b][w] <= pat(u, b, w);
      end else begin
        for (int b = 0; b < 16; b++)
          if (bank_we[u] && bank_cs[u][b]) mem[u][b][bank_addr[u]] <= bank_wdata[u];
      end
      cs_cnt[u] <= (bank_cs[u] == 16'h0) ? 0 : cs_cnt[u] + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic do_req(input int u, input logic we, input logic [11:0] addr,
                        input logic [7:0] wdata, input int hold);
    int n, lat, cs_good, cs_bad, we_cyc, en_cyc, sel_bad, addr_bad, rdy_bad, unstable;
    logic got;
    logic [7:0] expv, held;
    logic [3:0] b;
    logic [7:0] w;
    b = addr[11:8];
    w = addr[7:0];
    lat = (u == 0) ? 1 : 3;
    if (we) begin
      shadow[u][b][w] = wdata;
      expv = last_rd[u];
    end else begin
      expv = shadow[u][b][w];
      last_rd[u] = expv;
    end
    exp_q.push_back(expv);

    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready[u]), 32'd1);
    req_valid[u] = 1'b1; req_we[u] = we; req_addr[u] = addr; req_wdata[u] = wdata;
    rsp_ready[u] = (hold == 0);
    n = 0; got = 1'b0;
    cs_good = 0; cs_bad = 0; we_cyc = 0; en_cyc = 0; sel_bad = 0; addr_bad = 0; rdy_bad = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        req_valid[u] = 1'b0; req_we[u] = ~we; req_addr[u] = ~addr; req_wdata[u] = ~wdata;
      end
      if (bank_cs[u] == (16'h1 << b)) cs_good++;
      else if (bank_cs[u] != 16'h0) cs_bad++;
      if (bank_cs[u] != 16'h0 && (bank_addr[u] != w || (we && bank_wdata[u] != wdata))) addr_bad++;
      if (bank_we[u]) we_cyc++;
      if (mux_en[u]) begin
        en_cyc++;
        if (mux_sel[u] != b) sel_bad++;
      end
      if (req_ready[u]) rdy_bad++;
      if (rsp_valid[u]) got = 1'b1;
    end
    chk("rsp_latency", 32'(n), we ? 32'd2 : 32'(lat + 2));
    chk("cs_cycles", 32'(cs_good), we ? 32'd1 : 32'(lat + 1));
    chk("cs_onehot", 32'(cs_bad), 32'd0);
    chk("bank_addr_data", 32'(addr_bad), 32'd0);
    chk("we_cycles", 32'(we_cyc), we ? 32'd1 : 32'd0);
    chk("en_cycles", 32'(en_cyc), we ? 32'd0 : 32'd1);
    chk("mux_sel", 32'(sel_bad), 32'd0);
    chk("busy_ready", 32'(rdy_bad), 32'd0);
    chk("rsp_rdata", 32'(rsp_rdata[u]), 32'(exp_q.pop_front()));

    held = rsp_rdata[u];
    unstable = 0;
    for (int k = 0; k < hold; k++) begin
      req_valid[u] = 1'b1; req_we[u] = 1'b1; req_addr[u] = 12'h32A; req_wdata[u] = 8'h5A;
      @(negedge clk);
      if (!rsp_valid[u] || rsp_rdata[u] !== held || req_ready[u] || bank_cs[u] != 16'h0) unstable++;
    end
    if (hold > 0) chk("backpressure_stable", 32'(unstable), 32'd0);
    req_valid[u] = 1'b0;
    rsp_ready[u] = 1'b1;
    @(negedge clk);
    chk("idle_after_hs", 32'({rsp_valid[u], req_ready[u], mux_sel[u], mux_en[u]}),
        32'({1'b0, 1'b1, 4'h0, 1'b0}));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic saw_v;
    int n;
    req_valid = '0; req_we = '0; rsp_ready = '1; req_addr = '0; req_wdata = '0;
    last_rd[0] = 8'h00; last_rd[1] = 8'h00;
    for (int u = 0; u < 2; u++)
      for (int b = 0; b < 16; b++)
        for (int w = 0; w < 256; w++)
          shadow[u][b][w] = pat(u, b, w);

    // 1) reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk("reset_cs", 32'(bank_cs[u]), 32'd0);
      chk("reset_en_we_sel", 32'({mux_en[u], bank_we[u], mux_sel[u]}), 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid[u]), 32'd0);
      chk("reset_req_ready", 32'(req_ready[u]), 32'd1);
      chk("reset_rdata", 32'(rsp_rdata[u]), 32'd0);
    end
    fill = 1'b0;
    rst_n = 1'b1;

    // 2) write then read
    do_req(0, 1'b1, 12'h32A, 8'hA5, 0);
    do_req(0, 1'b0, 12'h32A, 8'h00, 0);

    // 3) bank sweep
    for (int i = 0; i < 16; i++) do_req(0, 1'b1, {4'(i), 8'h00}, 8'(i), 0);
    for (int i = 0; i < 16; i++) do_req(0, 1'b0, {4'(i), 8'h00}, 8'h00, 0);
    do_req(0, 1'b0, 12'h5FF, 8'h00, 0);

    // 4) backpressure; the ignored stray write must not land
    do_req(0, 1'b0, 12'h32A, 8'h00, 5);
    do_req(0, 1'b0, 12'h32A, 8'h00, 0);

    // 5) reset during CAPTURE
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 12'h710; rsp_ready[0] = 1'b1;
    @(negedge clk);
    req_valid[0] = 1'b0;
    n = 0;
    while (!mux_en[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("abort_in_capture", 32'(mux_en[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_cs_async", 32'(bank_cs[0]), 32'd0);
    chk("abort_en_async", 32'(mux_en[0]), 32'd0);
    saw_v = 1'b0;
    repeat (3) begin
      @(negedge clk);
      saw_v = saw_v | rsp_valid[0];
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      saw_v = saw_v | rsp_valid[0];
    end
    chk("abort_no_rsp", 32'(saw_v), 32'd0);
    chk("abort_rdata_cleared", 32'(rsp_rdata[0]), 32'd0);
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    do_req(0, 1'b0, 12'h710, 8'h00, 0);

    // 6) READ_LAT=3 instance, bank 15, all-ones word
    do_req(1, 1'b1, 12'hFFF, 8'h3C, 0);
    do_req(1, 1'b0, 12'hFFF, 8'h00, 0);
    do_req(1, 1'b0, 12'h0A0, 8'h00, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
